// File: rtl/dsp_pipe_reg_pkg.sv
// dsp_pkg: shared constants and parameter helpers for the DSP operand pipeline
package dsp_pkg;
  localparam int MAX_DEPTH = 4;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/dsp_pipe_cell.sv
// dsp_pipe_cell: one enabled pipeline register with synchronous clear
module dsp_pipe_cell
  import dsp_pkg::*;
#(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // clear beats enable, otherwise shift on ce or hold
  always_ff @(posedge clk) q <= (rst || flush) ? '0 : ce ? d : q;
endmodule

// File: rtl/dsp_pipe_reg.sv
// dsp_pipe_reg: DEPTH-stage operand pipeline with valid shadow, run-time tap, flush and busy
module dsp_pipe_reg
  import dsp_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2,
  parameter int TAPW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic [TAPW-1:0]  tap_sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy
);
  if (TAPW < clog2_min1(DEPTH + 1) || DEPTH < 0 || DEPTH > MAX_DEPTH || WIDTH < 1 || WIDTH > 48) begin : g_bad_params
    $error("dsp_pipe_reg: illegal WIDTH/DEPTH/TAPW combination");
  end
  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, ce, flush, tap_sel};
    assign out_data   = in_data;
    assign out_valid  = in_valid;
    assign busy       = 1'b0;
  end else begin : g_pipe
    logic [WIDTH:0] c [DEPTH+1];
    logic [WIDTH:0] sel;
    logic           any_v;
    assign c[0] = {in_data, in_valid};
    for (genvar i = 1; i <= DEPTH; i++) begin : g_cell
      dsp_pipe_cell #(.W(WIDTH + 1)) u_cell (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .ce   (ce),
        .d    (c[i-1]),
        .q    (c[i])
      );
    end
    // pick the deepest stage not beyond tap_sel, so oversized taps clamp to DEPTH
    always_comb begin
      sel = c[0];
      for (int k = 1; k <= DEPTH; k++) sel = (int'(tap_sel) >= k) ? c[k] : sel;
    end
    // occupancy looks only at registered valids, never at in_valid
    always_comb begin
      any_v = 1'b0;
      for (int k = 1; k <= DEPTH; k++) any_v = any_v | c[k][0];
    end
    assign out_data  = sel[WIDTH:1];
    assign out_valid = sel[0];
    assign busy      = any_v;
  end
endmodule

// File: tb/tb_dsp_pipe_reg.sv
// tb_dsp_pipe_reg: directed vectors with a scoreboard monitor for dsp_pipe_reg
module tb_dsp_pipe_reg;
  logic        clk = 1'b0;
  logic        rst, ce, flush, in_valid;
  logic [17:0] in_data, out_data;
  logic [2:0]  tap_sel;
  logic        out_valid, busy;
  logic        z_rst, z_ce, z_flush, z_valid;
  logic [17:0] z_data, z_out;
  logic [2:0]  z_tap;
  logic        z_ovalid, z_busy;
  logic        mon_en = 1'b0;
  logic [17:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          row_i = 0;

  always #5 clk = ~clk;

  dsp_pipe_reg #(.WIDTH(18), .DEPTH(2), .TAPW(3)) dut (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .tap_sel(tap_sel), .out_data(out_data), .out_valid(out_valid), .busy(busy)
  );

  dsp_pipe_reg #(.WIDTH(18), .DEPTH(0), .TAPW(3)) dut0 (
    .clk(clk), .rst(z_rst), .ce(z_ce), .flush(z_flush), .in_data(z_data), .in_valid(z_valid),
    .tap_sel(z_tap), .out_data(z_out), .out_valid(z_ovalid), .busy(z_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // inputs for one cycle, expected output seen in that cycle, expected busy
  task automatic row(input logic r, input logic c, input logic f, input logic [2:0] t,
                     input logic [17:0] d, input logic v,
                     input logic ev, input logic [17:0] ed, input logic eb);
    rst = r; ce = c; flush = f; tap_sel = t; in_data = d; in_valid = v;
    if (ev) exp_q.push_back(ed);
    @(negedge clk);
    chk($sformatf("busy_row%0d", row_i), {31'd0, busy}, {31'd0, eb});
    row_i++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got data %h expected no valid output", out_data);
      end else begin
        chk("out_data", {14'd0, out_data}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    z_rst = 1'b0; z_ce = 1'b0; z_flush = 1'b0; z_valid = 1'b0; z_data = '0; z_tap = '0;
    rst = 1'b1; ce = 1'b0; flush = 1'b0; tap_sel = 3'd2; in_data = 18'h3FFFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_out_data", {14'd0, out_data}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    //  rst ce fl tap  data      v   ev  exp       busy
    row(0, 1, 0, 2, 18'h00011, 1,  0, 18'h0,     0);
    row(0, 1, 0, 2, 18'h00022, 1,  0, 18'h0,     1);
    row(0, 1, 0, 2, 18'h00033, 1,  1, 18'h00011, 1);
    row(0, 1, 0, 2, 18'h00000, 0,  1, 18'h00022, 1);
    row(0, 1, 0, 2, 18'h00000, 0,  1, 18'h00033, 1);
    row(0, 1, 0, 2, 18'h00000, 0,  0, 18'h0,     0);
    row(0, 1, 0, 2, 18'h00044, 1,  0, 18'h0,     0);
    row(0, 1, 0, 2, 18'h00055, 1,  0, 18'h0,     1);
    row(0, 0, 0, 2, 18'h3FFFF, 1,  1, 18'h00044, 1);
    row(0, 0, 0, 2, 18'h3FFFF, 1,  1, 18'h00044, 1);
    row(0, 0, 0, 2, 18'h3FFFF, 1,  1, 18'h00044, 1);
    row(0, 1, 0, 2, 18'h00066, 1,  1, 18'h00044, 1);
    row(0, 1, 0, 2, 18'h00000, 0,  1, 18'h00055, 1);
    row(0, 1, 0, 2, 18'h00000, 0,  1, 18'h00066, 1);
    row(0, 1, 0, 2, 18'h00AAA, 1,  0, 18'h0,     0);
    row(0, 1, 0, 2, 18'h00BBB, 1,  0, 18'h0,     1);
    row(0, 1, 1, 2, 18'h00CCC, 1,  1, 18'h00AAA, 1);
    row(0, 0, 0, 1, 18'h00000, 0,  0, 18'h0,     0);
    row(0, 0, 0, 2, 18'h00000, 0,  0, 18'h0,     0);
    row(0, 1, 0, 2, 18'h00101, 1,  0, 18'h0,     0);
    row(0, 1, 0, 2, 18'h00202, 1,  0, 18'h0,     1);
    row(0, 0, 0, 0, 18'h00303, 1,  1, 18'h00303, 1);
    row(0, 0, 0, 1, 18'h00303, 1,  1, 18'h00202, 1);
    row(0, 0, 0, 2, 18'h00303, 1,  1, 18'h00101, 1);
    row(0, 0, 0, 7, 18'h00303, 1,  1, 18'h00101, 1);
    row(0, 1, 0, 0, 18'h00303, 0,  0, 18'h0,     1);
    row(0, 1, 0, 7, 18'h00000, 0,  1, 18'h00202, 1);
    row(0, 1, 0, 1, 18'h00000, 0,  0, 18'h0,     0);
    row(0, 1, 0, 1, 18'h00404, 1,  0, 18'h0,     0);
    row(1, 1, 0, 1, 18'h00505, 1,  1, 18'h00404, 1);
    row(0, 1, 0, 1, 18'h00606, 1,  0, 18'h0,     0);
    row(0, 0, 0, 1, 18'h00000, 0,  1, 18'h00606, 1);
    row(1, 0, 0, 0, 18'h00777, 1,  1, 18'h00777, 1);
    row(0, 0, 0, 0, 18'h00000, 0,  0, 18'h0,     0);
    mon_en = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    z_rst = 1'b1; z_tap = 3'd3; z_data = 18'h12345; z_valid = 1'b1;
    #1;
    chk("depth0_out_data", {14'd0, z_out}, 32'h12345);
    chk("depth0_out_valid", {31'd0, z_ovalid}, 32'd1);
    chk("depth0_busy", {31'd0, z_busy}, 32'd0);
    @(posedge clk);
    #1;
    z_rst = 1'b0; z_ce = 1'b1; z_tap = 3'd0; z_data = 18'h2ABCD; z_valid = 1'b0;
    #1;
    chk("depth0_tap0_data", {14'd0, z_out}, 32'h2ABCD);
    chk("depth0_tap0_valid", {31'd0, z_ovalid}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dsp_pipe_reg.md
Name: dsp_pipe_reg

Overview:
Parametrised pipeline register for DSP datapath operands. Generalises the single optional 18-bit register stage to WIDTH bits and DEPTH stages. Adds a per-stage valid shadow, a run-time output tap (bypass or 1..DEPTH cycles of delay), a flush, and a pipeline-occupancy indicator. Sits on operand and cascade paths ahead of the pre-adder and multiplier, with one instance per operand.

Parameters:
WIDTH, 18, data width in bits (1..48)
DEPTH, 2, number of physical register stages (0..4); 0 means the block is a pure wire
TAPW, 3, width of tap_sel; must be at least ceil(log2(DEPTH+1)), minimum 1

Ports:
clk  input  1  rising-edge clock; the only clock
rst  input  1  synchronous, active-high reset; all state cleared on the clk edge where rst=1
ce  input  1  clock enable; when 1, all stages shift by one
flush  input  1  synchronous clear of every stage, data and valid
in_data  input  WIDTH  operand in
in_valid  input  1  qualifier for in_data
tap_sel  input  TAPW  output tap: 0 = combinational bypass, k = output of stage k
out_data  output  WIDTH  selected operand
out_valid  output  1  valid qualifier of the selected tap
busy  output  1  1 when any stage holds a valid entry

Behaviour:
- Storage: stage[1..DEPTH] holds data (WIDTH bits) and v (1 bit). Stage 1 is fed from in_data/in_valid. Stage k is fed from stage k-1.
- Clock-edge priority: rst > flush > ce > hold.
  - rst=1: every stage data=0 and v=0, regardless of ce. Unlike the old stage, reset is not gated by enable.
  - flush=1 (rst=0): identical clear to rst, regardless of ce. in_data presented on that same edge is discarded.
  - ce=1: stage[1] <= {in_data, in_valid}, and stage[k] <= stage[k-1] for k = 2..DEPTH.
  - ce=0: every stage holds its value.
- Output selection is combinational from tap_sel:
  - tap_sel=0: out_data=in_data and out_valid=in_valid; zero latency.
  - 1 <= tap_sel <= DEPTH: out_data and out_valid come from stage[tap_sel]. Latency is tap_sel ce-qualified edges.
  - tap_sel > DEPTH: clamped to DEPTH. If DEPTH=0, clamped to 0.
- Reset values: all stage contents are 0 after reset, so out_data=0, out_valid=0 and busy=0 whenever tap_sel is nonzero. With tap_sel=0 the outputs follow the inputs even during reset.
- busy: OR of v over stages 1..DEPTH, registered-state only (in_valid has no effect). busy is 0 when DEPTH=0.
- Invalid entries: data of an invalid entry still shifts. No bubble collapsing. Data ordering is strictly FIFO by ce edges.
- tap_sel change mid-stream: takes effect combinationally in the same cycle. No state is disturbed and no data is duplicated or dropped inside the pipe.
- rst or flush asserted mid-operation: in-flight entries are lost. The first ce edge after release captures fresh input.
- DEPTH=0: no flops are generated; out_data=in_data and out_valid=in_valid for every tap_sel.
- Arithmetic: none. Data passes bit-exact with no sign extension.

Decomposition:
- Shared package dsp_pkg:
  - function clog2_min1 (returns at least 1), used to check TAPW;
  - localparam MAX_DEPTH=4;
  - elaboration check that TAPW is at least clog2_min1(DEPTH+1).
- One natural sub-module, dsp_pipe_cell: a single WIDTH+1-bit register with synchronous clear (rst|flush) and enable (ce). The top instantiates DEPTH cells in a generate loop and adds the tap mux and busy OR.

Test Plan:
1. Reset: WIDTH=18, DEPTH=2, tap_sel=2. Drive rst=1 with ce=0 and in_data=18'h3FFFF → after the edge, out_data=0, out_valid=0, busy=0. This confirms reset is independent of ce.
2. Latency: tap_sel=2, ce=1. Drive in_data 0x00011, 0x00022, 0x00033 with in_valid=1 on consecutive edges → out_data shows 0x00011 two edges after it was driven, then 0x00022 and 0x00033. out_valid rises two edges after the first in_valid.
3. Stall: same stream with ce=0 for 3 cycles after the 2nd sample → out_data is frozen at its current value for 3 cycles, then resumes with the next value. No loss or duplication.
4. Flush vs ce: stages hold 0x00AAA and 0x00BBB, both valid. Assert flush=1 with ce=1 and in_data=0x00CCC → next cycle busy=0 and out_valid=0 at taps 1 and 2. 0x00CCC never appears at the output.
5. Tap switching: a stream is in flight and tap_sel steps 0→1→2→7 → outputs equal in_data, then stage1, then stage2, then stage2 (clamped). The busy value is unaffected.
6. DEPTH=0 build: tap_sel=3 and in_data=0x12345 → out_data=0x12345 in the same cycle and busy=0. rst has no effect on out_data.
